// File: rtl/tuner_search_req_if.sv
// Bundles the host command, PHY search and lock result signals of the tuner search requester.
// The master modport is the requester's view; the slave modport is the host/PHY side.
interface tuner_search_req_if #(
   parameter int DAC_WIDTH     = 8,
   parameter int ADC_WIDTH     = 8,
   parameter int NUM_TARGET    = 4,
   parameter int TIMEOUT_WIDTH = 16
);
   localparam int IDX_W = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1;

   logic                     i_dig_cmd_val;
   logic                     o_dig_cmd_rdy;
   logic [DAC_WIDTH-1:0]     i_dig_cmd_tune_start;
   logic [DAC_WIDTH-1:0]     i_dig_cmd_tune_end;
   logic [DAC_WIDTH-1:0]     i_dig_cmd_tune_stride;
   logic                     i_dig_cmd_sel_mode;
   logic [IDX_W-1:0]         i_dig_cmd_sel_idx;
   logic [TIMEOUT_WIDTH-1:0] i_dig_cmd_timeout;

   logic                     o_dig_search_trig_val;
   logic                     i_dig_search_trig_rdy;
   logic [DAC_WIDTH-1:0]     o_dig_ring_tune_start;
   logic [DAC_WIDTH-1:0]     o_dig_ring_tune_end;
   logic [DAC_WIDTH-1:0]     o_dig_ring_tune_stride;

   logic                     i_dig_search_peaks_val;
   logic                     o_dig_search_peaks_rdy;
   logic [DAC_WIDTH-1:0]     i_dig_ring_tune_peaks [NUM_TARGET];
   logic [ADC_WIDTH-1:0]     i_dig_pwr_detected_peaks [NUM_TARGET];
   logic [IDX_W-1:0]         i_dig_ring_tune_peaks_cnt;

   logic                     o_dig_lock_val;
   logic                     i_dig_lock_rdy;
   logic [DAC_WIDTH-1:0]     o_dig_lock_tune;
   logic [ADC_WIDTH-1:0]     o_dig_lock_pwr;
   logic [1:0]               o_dig_lock_status;
   logic [2:0]               o_mon_state;

   modport master (
      input  i_dig_cmd_val, i_dig_cmd_tune_start, i_dig_cmd_tune_end, i_dig_cmd_tune_stride,
             i_dig_cmd_sel_mode, i_dig_cmd_sel_idx, i_dig_cmd_timeout,
             i_dig_search_trig_rdy, i_dig_search_peaks_val, i_dig_ring_tune_peaks,
             i_dig_pwr_detected_peaks, i_dig_ring_tune_peaks_cnt, i_dig_lock_rdy,
      output o_dig_cmd_rdy, o_dig_search_trig_val, o_dig_ring_tune_start, o_dig_ring_tune_end,
             o_dig_ring_tune_stride, o_dig_search_peaks_rdy, o_dig_lock_val, o_dig_lock_tune,
             o_dig_lock_pwr, o_dig_lock_status, o_mon_state
   );

   modport slave (
      output i_dig_cmd_val, i_dig_cmd_tune_start, i_dig_cmd_tune_end, i_dig_cmd_tune_stride,
             i_dig_cmd_sel_mode, i_dig_cmd_sel_idx, i_dig_cmd_timeout,
             i_dig_search_trig_rdy, i_dig_search_peaks_val, i_dig_ring_tune_peaks,
             i_dig_pwr_detected_peaks, i_dig_ring_tune_peaks_cnt, i_dig_lock_rdy,
      input  o_dig_cmd_rdy, o_dig_search_trig_val, o_dig_ring_tune_start, o_dig_ring_tune_end,
             o_dig_ring_tune_stride, o_dig_search_peaks_rdy, o_dig_lock_val, o_dig_lock_tune,
             o_dig_lock_pwr, o_dig_lock_status, o_mon_state
   );
endinterface

// File: rtl/tuner_search_req.sv
// Tuner search requester: triggers a PHY scan, captures its peak table and
// selects one peak (max power or by index) to return as the lock result.
module tuner_search_req #(
   parameter int DAC_WIDTH     = 8,
   parameter int ADC_WIDTH     = 8,
   parameter int NUM_TARGET    = 4,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   tuner_search_req_if.master  bus
);
   localparam int IDX_W = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_NO_PEAK = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_BAD_IDX = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TRIG = 3'd1,
      S_WAIT = 3'd2,
      S_SCAN = 3'd3,
      S_RESP = 3'd4
   } state_t;

   state_t                   r_state, w_next;
   logic [DAC_WIDTH-1:0]     r_start, r_end, r_stride;
   logic                     r_mode;
   logic [IDX_W-1:0]         r_sel_idx;
   logic [TIMEOUT_WIDTH-1:0] r_timeout, r_to_cnt;
   logic [DAC_WIDTH-1:0]     r_tunes [NUM_TARGET];
   logic [ADC_WIDTH-1:0]     r_pwrs  [NUM_TARGET];
   logic [IDX_W-1:0]         r_cnt, r_scan_idx;
   logic [DAC_WIDTH-1:0]     r_lock_tune;
   logic [ADC_WIDTH-1:0]     r_lock_pwr;
   logic [1:0]               r_status;
   logic                     w_timeout_hit, w_scan_last;

   assign w_timeout_hit = (r_timeout != '0) && (r_to_cnt == r_timeout - TIMEOUT_WIDTH'(1));
   // Mode 1 and the empty table both finish in the single SCAN cycle.
   assign w_scan_last   = (r_cnt == '0) || r_mode || (r_scan_idx == r_cnt - IDX_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: w_next gets its default first so no path through the case infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.i_dig_cmd_val)         w_next = S_TRIG;
         S_TRIG: if (bus.i_dig_search_trig_rdy) w_next = S_WAIT;
         S_WAIT: begin
            if (bus.i_dig_search_peaks_val) w_next = S_SCAN;
            else if (w_timeout_hit)         w_next = S_RESP;
         end
         S_SCAN: if (w_scan_last)       w_next = S_RESP;
         S_RESP: if (bus.i_dig_lock_rdy) w_next = S_IDLE;
         default:                        w_next = S_IDLE;
      endcase
   end

   // NOTE: the captured table is a handful of flops, not a RAM, so it is reset with everything else.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_start     <= '0;
         r_end       <= '0;
         r_stride    <= '0;
         r_mode      <= 1'b0;
         r_sel_idx   <= '0;
         r_timeout   <= '0;
         r_to_cnt    <= '0;
         r_cnt       <= '0;
         r_scan_idx  <= '0;
         r_lock_tune <= '0;
         r_lock_pwr  <= '0;
         r_status    <= ST_OK;
         for (int i = 0; i < NUM_TARGET; i++) begin
            r_tunes[i] <= '0;
            r_pwrs[i]  <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: if (bus.i_dig_cmd_val) begin
               r_start     <= bus.i_dig_cmd_tune_start;
               r_end       <= bus.i_dig_cmd_tune_end;
               r_stride    <= bus.i_dig_cmd_tune_stride;
               r_mode      <= bus.i_dig_cmd_sel_mode;
               r_sel_idx   <= bus.i_dig_cmd_sel_idx;
               r_timeout   <= bus.i_dig_cmd_timeout;
               r_lock_tune <= '0;
               r_lock_pwr  <= '0;
               r_status    <= ST_OK;
            end
            S_TRIG: if (bus.i_dig_search_trig_rdy) r_to_cnt <= '0;
            S_WAIT: begin
               r_to_cnt <= r_to_cnt + TIMEOUT_WIDTH'(1);
               if (bus.i_dig_search_peaks_val) begin
                  for (int i = 0; i < NUM_TARGET; i++) begin
                     r_tunes[i] <= bus.i_dig_ring_tune_peaks[i];
                     r_pwrs[i]  <= bus.i_dig_pwr_detected_peaks[i];
                  end
                  r_cnt      <= bus.i_dig_ring_tune_peaks_cnt;
                  r_scan_idx <= '0;
               end else if (w_timeout_hit) begin
                  r_status <= ST_TIMEOUT;
               end
            end
            S_SCAN: begin
               if (r_cnt == '0) begin
                  r_status    <= ST_NO_PEAK;
                  r_lock_tune <= '0;
                  r_lock_pwr  <= '0;
               end else if (r_mode) begin
                  if (r_sel_idx >= r_cnt) begin
                     r_status    <= ST_BAD_IDX;
                     r_lock_tune <= '0;
                     r_lock_pwr  <= '0;
                  end else begin
                     r_status    <= ST_OK;
                     r_lock_tune <= r_tunes[r_sel_idx];
                     r_lock_pwr  <= r_pwrs[r_sel_idx];
                  end
               end else begin
                  // Strictly-greater replacement keeps the lowest index on ties.
                  if ((r_scan_idx == '0) || (r_pwrs[r_scan_idx] > r_lock_pwr)) begin
                     r_lock_tune <= r_tunes[r_scan_idx];
                     r_lock_pwr  <= r_pwrs[r_scan_idx];
                  end
                  r_scan_idx <= r_scan_idx + IDX_W'(1);
                  r_status   <= ST_OK;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_dig_cmd_rdy          = (r_state == S_IDLE);
   assign bus.o_dig_search_trig_val  = (r_state == S_TRIG);
   assign bus.o_dig_search_peaks_rdy = (r_state == S_WAIT);
   assign bus.o_dig_lock_val         = (r_state == S_RESP);
   assign bus.o_dig_ring_tune_start  = r_start;
   assign bus.o_dig_ring_tune_end    = r_end;
   assign bus.o_dig_ring_tune_stride = r_stride;
   assign bus.o_dig_lock_tune        = r_lock_tune;
   assign bus.o_dig_lock_pwr         = r_lock_pwr;
   assign bus.o_dig_lock_status      = r_status;
   assign bus.o_mon_state            = r_state;
endmodule

// File: tb/tb_tuner_search_req.sv
// Directed bench for tuner_search_req: the bench plays both host and search PHY,
// driving on the falling edge and sampling outputs on the falling edge.
module tb_tuner_search_req;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NT = 4;
   localparam int TW = 16;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [DW-1:0] exp_s, exp_e, exp_st;

   tuner_search_req_if #(.DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_TARGET(NT), .TIMEOUT_WIDTH(TW)) bus ();

   tuner_search_req #(.DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_TARGET(NT), .TIMEOUT_WIDTH(TW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic init_inputs();
      bus.i_dig_cmd_val             = 1'b0;
      bus.i_dig_cmd_tune_start      = '0;
      bus.i_dig_cmd_tune_end        = '0;
      bus.i_dig_cmd_tune_stride     = '0;
      bus.i_dig_cmd_sel_mode        = 1'b0;
      bus.i_dig_cmd_sel_idx         = '0;
      bus.i_dig_cmd_timeout         = '0;
      bus.i_dig_search_trig_rdy     = 1'b0;
      bus.i_dig_search_peaks_val    = 1'b0;
      bus.i_dig_ring_tune_peaks_cnt = '0;
      bus.i_dig_lock_rdy            = 1'b0;
      for (int i = 0; i < NT; i++) begin
         bus.i_dig_ring_tune_peaks[i]    = '0;
         bus.i_dig_pwr_detected_peaks[i] = '0;
      end
   endtask

   // Issues a command; returns at the falling edge of cycle N+1 with cmd fields scrambled.
   task automatic send_cmd(input logic [DW-1:0] s, input logic [DW-1:0] e, input logic [DW-1:0] st,
                           input logic mode, input logic [IW-1:0] idx, input logic [TW-1:0] to);
      int n;
      @(negedge clk);
      bus.i_dig_cmd_tune_start  = s;
      bus.i_dig_cmd_tune_end    = e;
      bus.i_dig_cmd_tune_stride = st;
      bus.i_dig_cmd_sel_mode    = mode;
      bus.i_dig_cmd_sel_idx     = idx;
      bus.i_dig_cmd_timeout     = to;
      bus.i_dig_cmd_val         = 1'b1;
      exp_s = s; exp_e = e; exp_st = st;
      n = 0;
      while (bus.o_dig_cmd_rdy !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.o_dig_cmd_rdy !== 1'b1) begin
         errors++;
         $display("FAIL cmd_rdy_wait: cmd_rdy=%b required 1", bus.o_dig_cmd_rdy);
      end
      @(posedge clk);
      @(negedge clk);
      bus.i_dig_cmd_val         = 1'b0;
      bus.i_dig_cmd_tune_start  = ~s;
      bus.i_dig_cmd_tune_end    = ~e;
      bus.i_dig_cmd_tune_stride = ~st;
      bus.i_dig_cmd_sel_mode    = ~mode;
      bus.i_dig_cmd_sel_idx     = ~idx;
      bus.i_dig_cmd_timeout     = 16'd2;
      checks++;
      if ({bus.o_dig_search_trig_val, bus.o_dig_ring_tune_start, bus.o_dig_ring_tune_end,
           bus.o_dig_ring_tune_stride} !== {1'b1, s, e, st}) begin
         errors++;
         $display("FAIL cmd_accept: trig_val/range=%b/%h/%h/%h required 1/%h/%h/%h",
                  bus.o_dig_search_trig_val, bus.o_dig_ring_tune_start, bus.o_dig_ring_tune_end,
                  bus.o_dig_ring_tune_stride, s, e, st);
      end
   endtask

   // Holds trig_rdy low for 'hold' cycles, then accepts; returns at falling edge of T+1.
   task automatic send_trig(input int hold);
      int n;
      bus.i_dig_search_trig_rdy = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.o_dig_search_trig_val, bus.o_dig_ring_tune_start, bus.o_dig_ring_tune_end,
              bus.o_dig_ring_tune_stride} !== {1'b1, exp_s, exp_e, exp_st}) begin
            errors++;
            $display("FAIL trig_hold[%0d]: trig_val/range=%b/%h/%h/%h required 1/%h/%h/%h", i,
                     bus.o_dig_search_trig_val, bus.o_dig_ring_tune_start, bus.o_dig_ring_tune_end,
                     bus.o_dig_ring_tune_stride, exp_s, exp_e, exp_st);
         end
      end
      bus.i_dig_search_trig_rdy = 1'b1;
      n = 0;
      while (bus.o_dig_search_trig_val !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.i_dig_search_trig_rdy = 1'b0;
      checks++;
      if ({bus.o_dig_search_trig_val, bus.o_dig_search_peaks_rdy, bus.o_mon_state} !== {1'b0, 1'b1, 3'd2}) begin
         errors++;
         $display("FAIL trig_accept: trig_val/peaks_rdy/state=%b/%b/%0d required 0/1/2",
                  bus.o_dig_search_trig_val, bus.o_dig_search_peaks_rdy, bus.o_mon_state);
      end
   endtask

   // Presents the table (entry 0 in the low byte); returns at falling edge of P+1.
   task automatic send_peaks(input logic [31:0] codes, input logic [31:0] pwrs, input logic [IW-1:0] cnt);
      for (int i = 0; i < NT; i++) begin
         bus.i_dig_ring_tune_peaks[i]    = codes[i*8 +: 8];
         bus.i_dig_pwr_detected_peaks[i] = pwrs[i*8 +: 8];
      end
      bus.i_dig_ring_tune_peaks_cnt = cnt;
      bus.i_dig_search_peaks_val    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_dig_search_peaks_val    = 1'b0;
      bus.i_dig_ring_tune_peaks_cnt = ~cnt;
      for (int i = 0; i < NT; i++) begin
         bus.i_dig_ring_tune_peaks[i]    = 8'hEE;
         bus.i_dig_pwr_detected_peaks[i] = 8'hFF;
      end
   endtask

   // Sample n=1 is the current cycle; checks the sample where lock_val first reads 1.
   task automatic wait_lock(input int exp_n, input string name);
      int n;
      n = 1;
      while (bus.o_dig_lock_val !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL %s_latency: lock_val at cycle +%0d required +%0d", name, n, exp_n);
      end
   endtask

   task automatic finish_lock(input logic [DW-1:0] tune, input logic [AW-1:0] pwr, input logic [1:0] st,
                              input int hold, input string name);
      checks++;
      if ({bus.o_dig_lock_val, bus.o_dig_lock_tune, bus.o_dig_lock_pwr, bus.o_dig_lock_status} !==
          {1'b1, tune, pwr, st}) begin
         errors++;
         $display("FAIL %s_result: val/tune/pwr/status=%b/%0d/%0d/%0d required 1/%0d/%0d/%0d", name,
                  bus.o_dig_lock_val, bus.o_dig_lock_tune, bus.o_dig_lock_pwr, bus.o_dig_lock_status,
                  tune, pwr, st);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.o_dig_lock_val, bus.o_dig_lock_tune, bus.o_dig_lock_pwr, bus.o_dig_lock_status} !==
             {1'b1, tune, pwr, st}) begin
            errors++;
            $display("FAIL %s_hold[%0d]: val/tune/pwr/status=%b/%0d/%0d/%0d required 1/%0d/%0d/%0d", name, i,
                     bus.o_dig_lock_val, bus.o_dig_lock_tune, bus.o_dig_lock_pwr, bus.o_dig_lock_status,
                     tune, pwr, st);
         end
      end
      bus.i_dig_lock_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_dig_lock_rdy = 1'b0;
      checks++;
      if ({bus.o_dig_cmd_rdy, bus.o_dig_lock_val, bus.o_mon_state} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL %s_release: cmd_rdy/lock_val/state=%b/%b/%0d required 1/0/0", name,
                  bus.o_dig_cmd_rdy, bus.o_dig_lock_val, bus.o_mon_state);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({bus.o_mon_state, bus.o_dig_cmd_rdy, bus.o_dig_search_trig_val, bus.o_dig_search_peaks_rdy,
           bus.o_dig_lock_val, bus.o_dig_ring_tune_start, bus.o_dig_ring_tune_end, bus.o_dig_ring_tune_stride,
           bus.o_dig_lock_tune, bus.o_dig_lock_pwr, bus.o_dig_lock_status} !==
          {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'd0}) begin
         errors++;
         $display("FAIL %s: state=%0d rdy=%b trig=%b prdy=%b lval=%b rng=%h/%h/%h lock=%h/%h st=%0d required 0 1 0 0 0 zeros",
                  name, bus.o_mon_state, bus.o_dig_cmd_rdy, bus.o_dig_search_trig_val, bus.o_dig_search_peaks_rdy,
                  bus.o_dig_lock_val, bus.o_dig_ring_tune_start, bus.o_dig_ring_tune_end, bus.o_dig_ring_tune_stride,
                  bus.o_dig_lock_tune, bus.o_dig_lock_pwr, bus.o_dig_lock_status);
      end
   endtask

   task automatic test_reset();
      init_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_values");
      rst = 1'b0;
      // A stray peak table in IDLE must not be acknowledged.
      bus.i_dig_search_peaks_val = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({bus.o_dig_search_peaks_rdy, bus.o_mon_state} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL stray_peaks: peaks_rdy/state=%b/%0d required 0/0",
                     bus.o_dig_search_peaks_rdy, bus.o_mon_state);
         end
      end
      bus.i_dig_search_peaks_val = 1'b0;
   endtask

   task automatic test_max_power();
      send_cmd(8'd0, 8'd255, 8'd1, 1'b0, 2'd0, 16'd0);
      send_trig(0);
      send_peaks({8'd0, 8'd150, 8'd90, 8'd20}, {8'd0, 8'd120, 8'd200, 8'd40}, 2'd3);
      wait_lock(4, "max_power");
      finish_lock(8'd90, 8'd200, 2'd0, 0, "max_power");
   endtask

   task automatic test_tie();
      send_cmd(8'd0, 8'd100, 8'd2, 1'b0, 2'd0, 16'd0);
      send_trig(0);
      send_peaks({8'd0, 8'd60, 8'd30, 8'd10}, {8'd0, 8'd50, 8'd100, 8'd100}, 2'd3);
      wait_lock(4, "tie");
      finish_lock(8'd10, 8'd100, 2'd0, 0, "tie");
   endtask

   task automatic test_index();
      send_cmd(8'd3, 8'd9, 8'd1, 1'b1, 2'd2, 16'd0);
      send_trig(0);
      send_peaks({8'd0, 8'd7, 8'd6, 8'd5}, {8'd0, 8'd33, 8'd22, 8'd11}, 2'd3);
      wait_lock(2, "idx2");
      finish_lock(8'd7, 8'd33, 2'd0, 0, "idx2");
      send_cmd(8'd3, 8'd9, 8'd1, 1'b1, 2'd3, 16'd0);
      send_trig(0);
      send_peaks({8'd0, 8'd7, 8'd6, 8'd5}, {8'd0, 8'd33, 8'd22, 8'd11}, 2'd3);
      wait_lock(2, "idx3");
      finish_lock(8'd0, 8'd0, 2'd3, 0, "idx3");
   endtask

   task automatic test_timeout_no_peak();
      send_cmd(8'd1, 8'd200, 8'd5, 1'b0, 2'd0, 16'd50);
      send_trig(0);
      wait_lock(51, "timeout");
      checks++;
      if (bus.o_dig_search_peaks_rdy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_peaks_rdy: peaks_rdy=%b required 0", bus.o_dig_search_peaks_rdy);
      end
      finish_lock(8'd0, 8'd0, 2'd2, 0, "timeout");
      send_cmd(8'd1, 8'd200, 8'd5, 1'b0, 2'd0, 16'd0);
      send_trig(0);
      send_peaks({8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd9, 8'd9, 8'd9}, 2'd0);
      wait_lock(2, "no_peak");
      finish_lock(8'd0, 8'd0, 2'd1, 0, "no_peak");
   endtask

   task automatic test_back_pressure();
      send_cmd(8'd16, 8'd200, 8'd4, 1'b0, 2'd0, 16'd0);
      send_trig(20);
      send_peaks({8'd0, 8'd0, 8'd0, 8'd77}, {8'd0, 8'd0, 8'd0, 8'd9}, 2'd1);
      wait_lock(2, "bp");
      finish_lock(8'd77, 8'd9, 2'd0, 10, "bp");
   endtask

   task automatic test_reset_mid();
      send_cmd(8'd11, 8'd22, 8'd3, 1'b0, 2'd0, 16'd0);
      send_trig(0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset_in_wait");
      @(negedge clk);
      rst = 1'b0;
      send_cmd(8'd11, 8'd22, 8'd3, 1'b0, 2'd0, 16'd0);
      send_trig(0);
      send_peaks({8'd0, 8'd150, 8'd90, 8'd20}, {8'd0, 8'd120, 8'd200, 8'd40}, 2'd3);
      @(negedge clk);
      checks++;
      if (bus.o_mon_state !== 3'd3) begin
         errors++;
         $display("FAIL scan_state: state=%0d required 3", bus.o_mon_state);
      end
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset_in_scan");
      @(negedge clk);
      rst = 1'b0;
      send_cmd(8'd0, 8'd255, 8'd1, 1'b0, 2'd0, 16'd0);
      send_trig(0);
      send_peaks({8'd0, 8'd150, 8'd90, 8'd20}, {8'd0, 8'd120, 8'd200, 8'd40}, 2'd3);
      wait_lock(4, "after_reset");
      finish_lock(8'd90, 8'd200, 2'd0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_max_power();
      test_tie();
      test_index();
      test_timeout_no_peak();
      test_back_pressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
